tie_strap_sampler: RTL and testbench



---
 rtl/tie_strap_sampler.sv | 176 +++++++++++++++++
 tb/tb_tie_strap_sampler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tie_strap_sampler.sv
`timescale 1ns / 1ps
// Strap sampler: settles after reset, captures STRAP_IN once stable, locks it and flags later drift.
// Optional build macro TIE_STRAP_SYNC_EN adds a 2-flop synchroniser per strap bit.
module tie_strap_sampler #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned STABLE_COUNT  = 4,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] STRAP_IN,
    input  logic             SAMPLE_REQ,
    output logic [WIDTH-1:0] STRAP_Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             FAULT,
    output logic [WIDTH-1:0] FAULT_MASK
);

`ifdef TIE_STRAP_SYNC_EN
    localparam int unsigned SyncStages = 2;
`else
    localparam int unsigned SyncStages = 0;
`endif

    // Settle is stretched by the synchroniser depth so every latency shifts uniformly.
    localparam int unsigned SettleLast = SETTLE_CYCLES - 1 + SyncStages;
    localparam int unsigned SetW       = $clog2(SettleLast + 2);
    localparam int unsigned StbW       = $clog2(STABLE_COUNT + 2);
    localparam int unsigned RtyW       = $clog2(MAX_RETRIES + 2);

    typedef enum logic [1:0] {
        StSettle,
        StCapture,
        StLocked
    } state_e;

    logic [WIDTH-1:0] s;

`ifdef TIE_STRAP_SYNC_EN
    logic [1:0][WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        sync_d[0] = STRAP_IN;
        sync_d[1] = sync_q[0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[1];
`else
    assign s = STRAP_IN;
`endif

    state_e           state_q, state_d;
    logic [SetW-1:0]  settle_q, settle_d;
    logic [StbW-1:0]  stable_q, stable_d;
    logic [RtyW-1:0]  retry_q, retry_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] strap_q, strap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        cand_d   = cand_q;
        strap_d  = strap_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        unique case (state_q)
            StSettle: begin
                settle_d = settle_q + SetW'(1);
                if (settle_q == SetW'(SettleLast)) begin
                    state_d  = StCapture;
                    settle_d = '0;
                end
            end

            StCapture: begin
                // stable_q is zero only on the first capture cycle.
                if (stable_q == '0) begin
                    cand_d   = s;
                    stable_d = StbW'(1);
                end else if (s == cand_q) begin
                    stable_d = stable_q + StbW'(1);
                end else if (retry_q < RtyW'(MAX_RETRIES)) begin
                    cand_d   = s;
                    stable_d = StbW'(1);
                    retry_d  = retry_q + RtyW'(1);
                    mask_d   = mask_q | (cand_q ^ s);
                end else begin
                    state_d = StLocked;
                    strap_d = s;
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    mask_d  = mask_q | (cand_q ^ s);
                end

                if (state_d == StCapture && stable_d == StbW'(STABLE_COUNT)) begin
                    state_d = StLocked;
                    strap_d = cand_d;
                    valid_d = 1'b1;
                end
            end

            StLocked: begin
                // Re-capture wins over a coincident drift.
                if (SAMPLE_REQ) begin
                    state_d  = StSettle;
                    settle_d = '0;
                    stable_d = '0;
                    retry_d  = '0;
                    valid_d  = 1'b0;
                    fault_d  = 1'b0;
                    mask_d   = '0;
                end else if (s != strap_q) begin
                    fault_d = 1'b1;
                    mask_d  = mask_q | (s ^ strap_q);
                end
            end

            default: begin
                state_d = StSettle;
            end
        endcase

        busy_d = (state_d != StLocked);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StSettle;
            settle_q <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            cand_q   <= '0;
            strap_q  <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            cand_q   <= cand_d;
            strap_q  <= strap_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign STRAP_Q    = strap_q;
    assign VALID      = valid_q;
    assign BUSY       = busy_q;
    assign FAULT      = fault_q;
    assign FAULT_MASK = mask_q;

endmodule

// File: tb/tb_tie_strap_sampler.sv
`timescale 1ns / 1ps
// Directed bench for tie_strap_sampler; expected words queued as stimulus is driven.
module tb_tie_strap_sampler;

`ifdef TIE_STRAP_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] STRAP_IN;
    logic       SAMPLE_REQ;
    logic [7:0] STRAP_Q;
    logic       VALID;
    logic       BUSY;
    logic       FAULT;
    logic [7:0] FAULT_MASK;

    tie_strap_sampler dut (
        .CLK       (CLK),
        .RST       (RST),
        .STRAP_IN  (STRAP_IN),
        .SAMPLE_REQ(SAMPLE_REQ),
        .STRAP_Q   (STRAP_Q),
        .VALID     (VALID),
        .BUSY      (BUSY),
        .FAULT     (FAULT),
        .FAULT_MASK(FAULT_MASK)
    );

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [7:0] q, input logic v, input logic b,
                        input logic f, input logic [7:0] m);
        exp_t e;
        e.tag = tag;
        e.val = {q, v, b, f, m};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [18:0] obs;
        obs   = {STRAP_Q, VALID, BUSY, FAULT, FAULT_MASK};
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed q=%h v=%b b=%b f=%b m=%h required q=%h v=%b b=%b f=%b m=%h",
                        e.tag, obs[18:11], obs[10], obs[9], obs[8], obs[7:0],
                        e.val[18:11], e.val[10], e.val[9], e.val[8], e.val[7:0]);
        end
    endtask

    task automatic do_reset(input logic [7:0] v);
        STRAP_IN   = v;
        SAMPLE_REQ = 1'b0;
        RST        = 1'b1;
        tick(2);
        RST        = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        SAMPLE_REQ = 1'b0;
        STRAP_IN   = 8'hA5;
        tick(2);
        push("reset", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();

        // Clean lock
        RST = 1'b0;
        tick(16 + Lat);
        push("settle_busy", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(3);
        push("clean_pre", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(1);
        push("clean_lock", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        check();
        tick(5);
        push("clean_hold", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        check();

        // Recovered glitch on bit0 in the second capture cycle
        do_reset(8'h3C);
        tick(17);
        STRAP_IN = 8'h3D;
        tick(1);
        STRAP_IN = 8'h3C;
        tick(2 + Lat);
        push("glitch_mid", 8'h00, 1'b0, 1'b1, 1'b0, 8'h01);
        check();
        tick(1);
        push("glitch_busy", 8'h00, 1'b0, 1'b1, 1'b0, 8'h01);
        check();
        tick(1);
        push("glitch_lock", 8'h3C, 1'b1, 1'b0, 1'b0, 8'h01);
        check();

        // Retry exhaustion with toggling straps
        do_reset(8'h00);
        tick(17);
        STRAP_IN = 8'hFF;
        tick(1);
        STRAP_IN = 8'h00;
        tick(1);
        STRAP_IN = 8'hFF;
        tick(1);
        STRAP_IN = 8'h00;
        tick(1 + Lat);
        push("exhaust_lock", 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF);
        check();
        tick(3);
        push("exhaust_hold", 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF);
        check();

        // Drift while locked
        do_reset(8'h5A);
        tick(20 + Lat);
        push("drift_lock", 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
        check();
        STRAP_IN = 8'h7A;
        tick(1 + Lat);
        push("drift_fault", 8'h5A, 1'b1, 1'b0, 1'b1, 8'h20);
        check();
        STRAP_IN = 8'h5A;
        tick(2 + Lat);
        push("drift_sticky", 8'h5A, 1'b1, 1'b0, 1'b1, 8'h20);
        check();

        // Re-capture with a coincident strap change
        STRAP_IN   = 8'h11;
        SAMPLE_REQ = 1'b1;
        tick(1);
        SAMPLE_REQ = 1'b0;
        push("recap_start", 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(19 + Lat);
        push("recap_pre", 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(1);
        push("recap_lock", 8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
        check();

        // SAMPLE_REQ ignored in SETTLE and CAPTURE
        do_reset(8'h66);
        tick(4);
        SAMPLE_REQ = 1'b1;
        tick(1);
        SAMPLE_REQ = 1'b0;
        push("ign_settle", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(13 + Lat);
        SAMPLE_REQ = 1'b1;
        tick(1);
        SAMPLE_REQ = 1'b0;
        push("ign_capture", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        tick(1);
        push("ign_lock", 8'h66, 1'b1, 1'b0, 1'b0, 8'h00);
        check();

        // Reset mid-capture discards the candidate
        STRAP_IN   = 8'h99;
        SAMPLE_REQ = 1'b1;
        tick(1);
        SAMPLE_REQ = 1'b0;
        tick(18 + Lat);
        push("midcap_pre", 8'h66, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        RST = 1'b1;
        tick(1);
        push("midcap_reset", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check();
        RST = 1'b0;
        tick(20 + Lat);
        push("midcap_relock", 8'h99, 1'b1, 1'b0, 1'b0, 8'h00);
        check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
